// File: rtl/mdu_iterative_pkg.sv
// Shared pipeline package: MDU operation codes, MDU state encoding and step counts.
package pipes;

  typedef enum logic [3:0] {
    MDU_NOP,
    MDU_MUL,
    MDU_DIV,
    MDU_DIVU,
    MDU_REM,
    MDU_REMU,
    MDU_MULW,
    MDU_DIVW,
    MDU_DIVUW,
    MDU_REMW,
    MDU_REMUW
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_BUSY,
    MDU_DONE
  } mdu_state_t;

  localparam int unsigned MDU_STEPS_D = 64;
  localparam int unsigned MDU_STEPS_W = 32;

  function automatic logic mdu_is_w(input mdu_op_t op);
    return (op == MDU_MULW) || (op == MDU_DIVW) || (op == MDU_DIVUW) ||
           (op == MDU_REMW) || (op == MDU_REMUW);
  endfunction

  function automatic logic mdu_is_mul(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_MULW);
  endfunction

  // Any quotient or remainder operation.
  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU) ||
           (op == MDU_DIVW) || (op == MDU_DIVUW) || (op == MDU_REMW) || (op == MDU_REMUW);
  endfunction

  function automatic logic mdu_is_rem(input mdu_op_t op);
    return (op == MDU_REM) || (op == MDU_REMU) || (op == MDU_REMW) || (op == MDU_REMUW);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_REM) || (op == MDU_DIVW) || (op == MDU_REMW);
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/response handshake bundle between the execute stage and the MDU.
interface mdu_iterative_if #(
  parameter int unsigned XLEN = 64
);
  import pipes::*;

  logic            in_valid;
  logic            in_ready;
  mdu_op_t         op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle; also owns the MDU step counter.
module mdu_div_core
  import pipes::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic            step,
  input  logic            w_mode,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  localparam bit HAS_W = (XLEN == 64);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [6:0]      cnt_q;
  logic            half_q;

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] trial;
  logic            fits;

  // Next-step values are exported so the top can register the final result on the last step.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted[XLEN-1:0] - dvs_q;
    fits    = shifted >= {1'b0, dvs_q};
    rem_nxt = fits ? trial : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], fits};
    last    = cnt_q == (half_q ? 7'(MDU_STEPS_W - 1) : 7'(XLEN - 1));
  end

  // A 32-step run is left-aligned so the dividend MSB is consumed first.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      half_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      half_q <= HAS_W && w_mode;
      quo_q  <= (HAS_W && w_mode) ? (dividend << MDU_STEPS_W) : dividend;
      dvs_q  <= divisor;
    end else if (step) begin
      cnt_q <= cnt_q + 7'd1;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes.
// Optional macro MDU_FAST_MUL_EN: MUL/MULW complete in one cycle with a '*' multiplier.
module mdu_iterative
  import pipes::*;
#(
  parameter int unsigned XLEN = 64
) (
  input logic           clk,
  input logic           reset,
  mdu_iterative_if.slave bus
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  mdu_state_t      state;
  logic            out_valid_q;
  logic [XLEN-1:0] out_data_q;

  logic            w_q;
  logic            mul_q;
  logic            is_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;

  logic            in_ready;
  logic            accept;
  logic            is_w;
  logic            is_mul;
  logic            is_div;
  logic            is_rem;
  logic            is_sgn;
  logic            sa;
  logic            sb;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic [31:0]     a_lo;
  logic [31:0]     b_lo;
  logic [31:0]     a_abs32;
  logic [31:0]     b_abs32;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] a_res;
  logic [XLEN-1:0] special_res;
`ifdef MDU_FAST_MUL_EN
  logic [XLEN-1:0] prod;
`endif

  logic            core_last;
  logic [XLEN-1:0] core_quo;
  logic [XLEN-1:0] core_rem;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] sel_res;
  logic [XLEN-1:0] final_res;

  assign in_ready      = (state == MDU_IDLE) && !reset;
  assign accept        = bus.in_valid && in_ready && !bus.flush;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Operand decode, magnitude extraction and single-cycle special cases.
  always_comb begin
    a_lo    = bus.a[31:0];
    b_lo    = bus.b[31:0];
    is_w    = mdu_is_w(bus.op);
    is_mul  = mdu_is_mul(bus.op);
    is_div  = mdu_is_div(bus.op);
    is_rem  = mdu_is_rem(bus.op);
    is_sgn  = mdu_is_signed(bus.op);
    sa      = 1'b0;
    sb      = 1'b0;
    a_abs32 = a_lo;
    b_abs32 = b_lo;
    a_mag   = bus.a;
    b_mag   = bus.b;
    b_zero  = 1'b0;
    ovf     = 1'b0;
    a_res   = bus.a;
    if (is_w) begin
      sa      = is_sgn && a_lo[31];
      sb      = is_sgn && b_lo[31];
      a_abs32 = sa ? (~a_lo + 32'd1) : a_lo;
      b_abs32 = sb ? (~b_lo + 32'd1) : b_lo;
      a_mag   = XLEN'(a_abs32);
      b_mag   = XLEN'(b_abs32);
      b_zero  = (b_lo == '0);
      ovf     = is_sgn && (a_lo == 32'h8000_0000) && (b_lo == '1);
      a_res   = sext32(a_lo);
    end else begin
      sa     = is_sgn && bus.a[XLEN-1];
      sb     = is_sgn && bus.b[XLEN-1];
      a_mag  = sa ? (~bus.a + XLEN'(1)) : bus.a;
      b_mag  = sb ? (~bus.b + XLEN'(1)) : bus.b;
      b_zero = (bus.b == '0);
      ovf    = is_sgn && (bus.a == XMIN) && (bus.b == '1);
    end

    special     = 1'b0;
    special_res = '0;
`ifdef MDU_FAST_MUL_EN
    prod        = bus.a * bus.b;
`endif
    if (bus.op == MDU_NOP) begin
      special = 1'b1;
    end else if (is_div && b_zero) begin
      special     = 1'b1;
      special_res = is_rem ? a_res : '1;
    end else if (is_div && ovf) begin
      special     = 1'b1;
      special_res = is_rem ? '0 : a_res;
    end
`ifdef MDU_FAST_MUL_EN
    else if (is_mul) begin
      special     = 1'b1;
      special_res = is_w ? sext32(prod[31:0]) : prod;
    end
`endif
  end

  // Shift-add step and sign post-processing of the divider result.
  always_comb begin
    acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
    quo_s     = neg_quo_q ? (~core_quo + XLEN'(1)) : core_quo;
    rem_s     = neg_rem_q ? (~core_rem + XLEN'(1)) : core_rem;
    sel_res   = mul_q ? acc_nxt : (is_rem_q ? rem_s : quo_s);
    final_res = w_q ? sext32(sel_res[31:0]) : sel_res;
  end

  mdu_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk      (clk),
    .reset    (reset),
    .abort    (bus.flush),
    .start    (accept && !special),
    .step     (state == MDU_BUSY),
    .w_mode   (is_w),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last     (core_last),
    .quo_nxt  (core_quo),
    .rem_nxt  (core_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MDU_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      w_q         <= 1'b0;
      mul_q       <= 1'b0;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else if (bus.flush) begin
      state       <= MDU_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            if (special) begin
              state       <= MDU_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= special_res;
            end else begin
              state     <= MDU_BUSY;
              w_q       <= is_w;
              mul_q     <= is_mul;
              is_rem_q  <= is_rem;
              neg_quo_q <= sa ^ sb;
              neg_rem_q <= sa;
              mcand_q   <= bus.a;
              mplier_q  <= bus.b;
              acc_q     <= '0;
            end
          end
        end
        MDU_BUSY: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (core_last) begin
            state       <= MDU_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= final_res;
          end
        end
        MDU_DONE: begin
          if (bus.out_ready) begin
            state       <= MDU_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (XLEN=64) against an arithmetic reference model.
module tb_mdu_iterative;
  import pipes::*;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam int MUL_LAT_D = FAST_MUL ? 1 : 65;
  localparam int MUL_LAT_W = FAST_MUL ? 1 : 33;

  typedef struct {
    mdu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mdu_iterative_if #(.XLEN(64)) bus ();

  mdu_iterative #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua, ub;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua = a[31:0]; ub = b[31:0];
    r = '0;
    case (op)
      MDU_MUL:   r = a * b;
      MDU_DIVU:  r = (b == 0) ? '1 : a / b;
      MDU_REMU:  r = (b == 0) ? a : a % b;
      MDU_DIV:   if (b == 0) r = '1; else if (a == MIN64 && sb == -1) r = a; else r = sa / sb;
      MDU_REM:   if (b == 0) r = a; else if (a == MIN64 && sb == -1) r = 0; else r = sa % sb;
      MDU_MULW:  r = sx(32'(ua * ub));
      MDU_DIVUW: r = (ub == 0) ? '1 : sx(ua / ub);
      MDU_REMUW: r = (ub == 0) ? sx(ua) : sx(ua % ub);
      MDU_DIVW:  if (ub == 0) r = '1; else if (ua == 32'h8000_0000 && sb32 == -1) r = sx(ua);
                 else r = sx(32'(sa32 / sb32));
      MDU_REMW:  if (ub == 0) r = sx(ua); else if (ua == 32'h8000_0000 && sb32 == -1) r = 0;
                 else r = sx(32'(sa32 % sb32));
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    bit w, sgn, bzero, ovf;
    w   = op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    sgn = op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    if (op == MDU_NOP) return 1;
    if (op == MDU_MUL || op == MDU_MULW) return FAST_MUL ? 1 : (w ? 33 : 65);
    bzero = w ? (b[31:0] == 0) : (b == 0);
    ovf   = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == MIN64 && b == '1));
    return (bzero || ovf) ? 1 : (w ? 33 : 65);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns #1 after its accept edge (cycle k+1).
  task automatic issue(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready %s: in_ready=%b required 1", op.name(), bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.in_valid = 1'b0;
    bus.op = MDU_DIV;
    bus.a = {$urandom(), $urandom()};
    bus.b = {$urandom(), $urandom()};
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks += 3;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    vec_t v[12];
    int   lat;
    v = '{
      '{MDU_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT_D},
      '{MDU_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65},
      '{MDU_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65},
      '{MDU_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{MDU_REMU,  64'd5, 64'd0, 64'd5, 1},
      '{MDU_DIV,   MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 1},
      '{MDU_REM,   MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1},
      '{MDU_REMUW, 64'h1_0000_000A, 64'd3, 64'd1, 33},
      '{MDU_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1},
      '{MDU_MULW,  64'h1_0000, 64'h1_0000, 64'd0, MUL_LAT_W},
      '{MDU_NOP,   64'd123, 64'd456, 64'd0, 1},
      '{MDU_DIVUW, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33}
    };
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_valid(lat);
      checks += 2;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL dir_lat[%0d] %s: got %0d required %0d", i, v[i].op.name(), lat, v[i].lat);
      end
      if (bus.out_data !== v[i].exp) begin
        errors++;
        $display("FAIL dir_data[%0d] %s: got %h required %h", i, v[i].op.name(), bus.out_data, v[i].exp);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    mdu_op_t     ops[11];
    mdu_op_t     op;
    logic [63:0] a, b, exp;
    int          lat, elat;
    bit          w;
    ops = '{MDU_NOP, MDU_MUL, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
            MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 10)];
      w  = op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0: b = w ? {$urandom(), 32'd0} : 64'd0;
        1: begin
          a = w ? {$urandom(), 32'h8000_0000} : MIN64;
          b = w ? {$urandom(), 32'hFFFF_FFFF} : '1;
        end
        2: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 17)); end
        3: b = {32'd0, 16'd0, 16'($urandom())};
        default: ;
      endcase
      exp  = ref_result(op, a, b);
      elat = exp_lat(op, a, b);
      issue(op, a, b);
      wait_valid(lat);
      checks += 2;
      if (lat !== elat) begin
        errors++;
        $display("FAIL rnd_lat[%0d] %s a=%h b=%h: got %0d required %0d", i, op.name(), a, b, lat, elat);
      end
      if (bus.out_data !== exp) begin
        errors++;
        $display("FAIL rnd_data[%0d] %s a=%h b=%h: got %h required %h", i, op.name(), a, b, bus.out_data, exp);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [63:0] a, b, exp;
    int          lat;
    a = {$urandom(), $urandom()};
    b = {32'd0, $urandom()} | 64'd1;
    exp = ref_result(MDU_DIVU, a, b);
    issue(MDU_DIVU, a, b);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b required 1", i, bus.out_valid); end
      if (bus.out_data !== exp) begin errors++; $display("FAIL hold_data[%0d]: got %h required %h", i, bus.out_data, exp); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, bus.in_ready); end
      tick();
    end
    release_result();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_flush();
    int seen = 0;
    int lat;
    issue(MDU_DIVU, {$urandom(), $urandom()}, {32'd0, $urandom()} | 64'd1);
    for (int i = 0; i < 9; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b required 0", bus.out_valid); end
    for (int i = 0; i < 80; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_result: out_valid cycles %0d required 0", seen); end

    issue(MDU_DIVU, 64'd100, 64'd7);
    wait_valid(lat);
    checks += 2;
    if (lat !== 65) begin errors++; $display("FAIL after_flush_lat: got %0d required 65", lat); end
    if (bus.out_data !== 64'd14) begin errors++; $display("FAIL after_flush_data: got %h required 14", bus.out_data); end
    release_result();

    // Flush beats a same-cycle request.
    bus.in_valid = 1'b1; bus.op = MDU_DIVU; bus.a = 64'd5; bus.b = 64'd0; bus.flush = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_prio_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_prio_ready: got %b required 1", bus.in_ready); end

    // Flush beats out_ready while a result is held.
    issue(MDU_REMU, 64'd9, 64'd0);
    wait_valid(lat);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] a;
      a = {$urandom(), $urandom()};
      issue(MDU_REMU, a, 64'd0);
      wait_valid(lat);
      checks += 3;
      if (lat !== 1) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d required 1", i, lat); end
      if (bus.out_data !== a) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, bus.out_data, a); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d]: in_ready=%b required 0", i, bus.in_ready); end
      tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, bus.in_ready); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(MDU_DIVU, 64'd1000, 64'd3);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", bus.out_valid); end
    if (bus.out_data !== 64'd0) begin errors++; $display("FAIL rst_mid_data: got %h required 0", bus.out_data); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b required 0", bus.in_ready); end
    reset = 1'b0;
    tick();
    issue(MDU_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    wait_valid(lat);
    checks += 2;
    if (lat !== 65) begin errors++; $display("FAIL rst_after_lat: got %0d required 65", lat); end
    if (bus.out_data !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++; $display("FAIL rst_after_data: got %h required fffffffffffffffa", bus.out_data);
    end
    release_result();
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.op = MDU_NOP; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Parametrised iterative multiply/divide unit for the RV64 core's execute stage. It implements every `mdu_op_t` operation over a configurable `XLEN`, including the 32-bit W variants. It uses a valid/ready handshake on both input and output, so the pipeline stalls on it the same way it stalls on memory. Results follow RISC-V M-extension semantics, including divide-by-zero and signed overflow.

## Interface
- `XLEN`, default 64: operand/result width; must be 64 or 32. W ops are legal only when `XLEN`=64.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request; equals `state==MDU_IDLE && !reset`.
- `op` in `mdu_op_t`: operation; sampled on accept.
- `a`, `b` in `XLEN`: operands (rs1, rs2); sampled on accept.
- `flush` in 1: abort any operation; no result is produced.
- `out_valid` out 1: result present; registered.
- `out_ready` in 1: consumer takes the result.
- `out_data` out `XLEN`: result; registered; stable while `out_valid` && !`out_ready`.

## Operation
- States (`mdu_state_t`):
  - `MDU_IDLE` → `MDU_BUSY` on accept (`in_valid && in_ready && !flush`) of an iterative op.
  - `MDU_IDLE` → `MDU_DONE` directly on accept of a special case.
  - `MDU_BUSY` → `MDU_DONE` after the last step.
  - `MDU_DONE` → `MDU_IDLE` when `out_ready`.
- Step count N: 64 for XLEN-wide ops at `XLEN`=64; 32 for W ops and for `XLEN`=32.
- W ops:
  - Use operand bits [31:0] only.
  - The 32-bit result is sign-extended to `XLEN`; this applies to DIVUW/REMUW too.
- MUL/MULW: only the low product half is needed, so the multiply is an unsigned shift-add, one multiplier bit per step.
- DIV/REM (signed):
  - Divide |a| by |b| on the unsigned core.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
- DIVU/REMU: unsigned restoring division, one quotient bit per step.
- Special cases complete with no iteration:
  - b==0: quotient = all-ones; remainder = a (W: a[31:0] sign-extended).
  - Signed overflow (a = most-negative, b = −1): quotient = a; remainder = 0.
  - `MDU_NOP`: result 0.
- Flush:
  - From any state, next state is `MDU_IDLE`, `out_valid` is 0 next cycle, and the in-progress result is discarded.
  - Flush has priority over a same-cycle `in_valid` (the request is not accepted) and over `out_ready`.
- Reset: state `MDU_IDLE`, `out_valid`=0, `out_data`=0, step counter=0, `in_ready`=0 while `reset` is high.

## Timing
- Accept in cycle k, iterative op: `MDU_BUSY` in cycles k+1..k+N, `out_valid`=1 from cycle k+N+1.
- Accept in cycle k, special case: `out_valid`=1 in cycle k+1.
- `out_valid` is held until the `out_ready` cycle; `in_ready` rises the following cycle.
- Minimum issue interval: N+2 cycles (iterative), 2 cycles (special).
- Operand changes after the accept cycle have no effect.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MUL/MULW are computed with a single-cycle `*` and registered, with `out_valid` in cycle k+1.
  - Division is unchanged.
- `MDU_FAST_MUL_EN` undefined: MUL/MULW use the N-step shift-add. No multiplier is inferred.

## Structure
- Shared `pipes` package:
  - `mdu_op_t` (existing).
  - New `mdu_state_t {MDU_IDLE, MDU_BUSY, MDU_DONE}`.
  - Constants `MDU_STEPS_D`=64 and `MDU_STEPS_W`=32.
- Sub-module `mdu_div_core`: one restoring-division step per cycle, holding the unsigned remainder and quotient registers plus the step counter.
- The top module holds:
  - sign pre/post-processing;
  - special-case detection;
  - the shift-add multiplier;
  - the state machine;
  - the output register.

## Test plan
- MUL, a=7, b=0xFFFFFFFFFFFFFFFD → `out_data`=0xFFFFFFFFFFFFFFEB, `out_valid` in cycle k+65 (k+1 with `MDU_FAST_MUL_EN`).
- DIV a=−20, b=3 → 0xFFFFFFFFFFFFFFFA (−6); REM with the same operands → 0xFFFFFFFFFFFFFFFE (−2); each at k+65.
- Special cases:
  - DIVU a=5, b=0 → 0xFFFFFFFFFFFFFFFF.
  - REMU a=5, b=0 → 5.
  - DIV a=0x8000000000000000, b=−1 → 0x8000000000000000.
  - REM with the same operands → 0.
  - Each result at k+1.
- W ops:
  - REMUW a=0x1_0000000A, b=3 → 1 at k+33.
  - DIVW a=0x80000000, b=0xFFFFFFFF → 0xFFFFFFFF80000000 at k+1.
  - MULW a=b=0x10000 → 0.
- Flush and back-to-back:
  - Assert `flush` in cycle k+10 of a DIVU → `out_valid` never rises; `in_ready`=1 in cycle k+11.
  - Then DIVU 100/7 → 14.
- Output hold and reset:
  - With `out_ready`=0 for 5 cycles after `out_valid`, `out_data` stays stable and `in_ready`=0.
  - Assert `reset` mid-BUSY → `out_valid`=0 and `out_data`=0 the next cycle.
